// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial add controller. A single one-bit full-adder slice (3-input XOR
//   LUT for SUM, carry-cell majority for COUT) is stepped over a WIDTH-bit
//   operand pair at one bit per clock. The result and carry-out appear together
//   on a one-cycle DONE pulse and then hold until the next completion.
//
//   Optional build macro: SERIAL_ADD_CTRL_SUB_EN
//     When defined, adds input SUB. SUB=1 turns the operation into I0 - I1
//     (operand B is inverted and the carry is forced to 1, CIN is ignored).
//     COUT=1 then means "no borrow". When undefined, the block only adds.
//
// Parameters
//   WIDTH  operand/result width, 1..32
//
// Ports
//   CLKIN   in   clock, rising edge
//   RESET   in   synchronous active-high reset
//   START   in   request, accepted only on an edge where READY=1
//   I0      in   operand A, sampled on the accepting edge
//   I1      in   operand B, sampled on the accepting edge
//   CIN     in   carry-in, sampled on the accepting edge
//   SUB     in   subtract select (SERIAL_ADD_CTRL_SUB_EN builds only)
//   READY   out  idle or done, a new START will be taken
//   BUSY    out  serial computation in progress
//   DONE    out  one-cycle pulse, O/COUT carry the new result
//   O       out  registered sum
//   COUT    out  registered carry-out of bit WIDTH-1
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLKIN,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             CIN,
`ifdef SERIAL_ADD_CTRL_SUB_EN
  input  logic             SUB,
`endif
  output logic             READY,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] O,
  output logic             COUT
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  // LUT4 init for SUM = I0 ^ I1 ^ CIN; index is {I3, I2, I1, I0}, I3 unused.
  localparam logic [15:0] SUM_LUT = 16'h9696;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               slice_sum;
  logic               slice_cout;
  logic [WIDTH-1:0]   sum_shift;
  logic               last_bit;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;

  // One-bit full-adder slice fed from the operand LSBs and the carry flop.
  always_comb begin
    slice_sum  = SUM_LUT[{1'b0, carry_q, b_q[0], a_q[0]}];
    slice_cout = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] | b_q[0]));
  end

  // Sum register fills MSB-first; after WIDTH shifts bit 0 holds the first bit.
  always_comb begin
    sum_shift = (sum_q >> 1) | (WIDTH'(slice_sum) << (WIDTH - 1));
    last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Operand-B and carry values loaded on an accepting edge.
  always_comb begin
    b_load     = I1;
    carry_load = CIN;
`ifdef SERIAL_ADD_CTRL_SUB_EN
    if (SUB) begin
      // Two's-complement subtract: A + ~B + 1.
      b_load     = ~I1;
      carry_load = 1'b1;
    end
`endif
  end

  // Control FSM and serial datapath; every output is a flop.
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      READY   <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      O       <= '0;
      COUT    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE_ST: begin
          DONE <= 1'b0;
          if (START) begin
            state   <= RUN;
            a_q     <= I0;
            b_q     <= b_load;
            carry_q <= carry_load;
            sum_q   <= '0;
            cnt_q   <= '0;
            READY   <= 1'b0;
            BUSY    <= 1'b1;
          end else begin
            state <= IDLE;
            READY <= 1'b1;
            BUSY  <= 1'b0;
          end
        end

        RUN: begin
          // START is deliberately ignored here; there is no request queue.
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= slice_cout;
          sum_q   <= sum_shift;
          if (last_bit) begin
            state <= DONE_ST;
            O     <= sum_shift;
            COUT  <= slice_cout;
            cnt_q <= '0;
            READY <= 1'b1;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          READY <= 1'b1;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//   Self-checking bench for serial_add_ctrl at WIDTH=8: a table of directed
//   operand vectors, hand-written sequences for the multi-cycle corners, and
//   a randomized run against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             CLKIN;
  logic             RESET;
  logic             START;
  logic [WIDTH-1:0] I0;
  logic [WIDTH-1:0] I1;
  logic             CIN;
  logic             SUB;
  logic             READY;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] O;
  logic             COUT;

  int tests;
  int fails;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .CLKIN (CLKIN),
    .RESET (RESET),
    .START (START),
    .I0    (I0),
    .I1    (I1),
    .CIN   (CIN),
`ifdef SERIAL_ADD_CTRL_SUB_EN
    .SUB   (SUB),
`endif
    .READY (READY),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .O     (O),
    .COUT  (COUT)
  );

  initial begin
    CLKIN = 1'b0;
    forever #5 CLKIN = ~CLKIN;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] o;
    logic       cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLKIN);
    #1;
  endtask

  // Issue one operation from an idle DUT and check latency, handshake and result.
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub,
                        input logic [7:0] eo, input logic ec);
    int lat;
    bit seen;
    bit ready_leak;
    I0 = a; I1 = b; CIN = cin; SUB = sub; START = 1'b1;
    tick;
    START = 1'b0;
    check({name, "_accept"}, {30'd0, READY, BUSY}, 32'h1);
    lat = 0; seen = 0; ready_leak = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick;
      lat++;
      if (DONE) seen = 1;
      else if (READY) ready_leak = 1;
    end
    check({name, "_latency"}, 32'(lat), 32'(WIDTH));
    check({name, "_ready_low"}, {31'd0, ready_leak}, 32'h0);
    check({name, "_o"}, {24'd0, O}, {24'd0, eo});
    check({name, "_cout"}, {31'd0, COUT}, {31'd0, ec});
    tick;
    check({name, "_done_fall"}, {29'd0, READY, BUSY, DONE}, 32'h4);
  endtask

  vec_t vecs[8];

  // Reference-model state for the randomized run.
  int         m_rem;
  logic       m_ready, m_busy, m_done, m_cout;
  logic [7:0] m_o;
  logic [7:0] p_o;
  logic       p_c;

  initial begin
    int done_cnt;
    int done_pos[$];
    logic [7:0] cap_o;
    int full;
    logic r_reset, r_start, r_cin, r_sub;
    logic [7:0] r_a, r_b;

    tests = 0; fails = 0;
    RESET = 1'b1; START = 1'b0; I0 = '0; I1 = '0; CIN = 1'b0; SUB = 1'b0;

    vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};

    tick; tick;
    RESET = 1'b0;
    check("reset_state", {20'd0, READY, BUSY, DONE, COUT, O}, {20'd0, 4'b1000, 8'h00});
    tick;
    check("idle_hold", {20'd0, READY, BUSY, DONE, COUT, O}, {20'd0, 4'b1000, 8'h00});

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
             vecs[i].o, vecs[i].cout);

`ifdef SERIAL_ADD_CTRL_SUB_EN
    run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    run_op("sub_00_01", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0);
    run_op("sub_cin_ignored", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1);
    SUB = 1'b0;
`endif

    // START pulsed mid-RUN must be dropped.
    I0 = 8'h10; I1 = 8'h20; CIN = 1'b0; START = 1'b1;
    tick;
    START = 1'b0;
    tick; tick; tick;
    I0 = 8'h01; I1 = 8'h01; START = 1'b1;
    tick;
    START = 1'b0;
    done_cnt = 0; cap_o = 8'h00;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (DONE) begin done_cnt++; cap_o = O; end
    end
    check("ignore_start_dones", 32'(done_cnt), 32'd1);
    check("ignore_start_o", {24'd0, cap_o}, 32'h30);
    check("ignore_start_idle", {29'd0, READY, BUSY, DONE}, 32'h4);

    // START held: one result every WIDTH+1 cycles.
    I0 = 8'h12; I1 = 8'h34; CIN = 1'b0; START = 1'b1;
    done_pos.delete();
    for (int c = 0; c < 30; c++) begin
      tick;
      if (DONE) begin
        done_pos.push_back(c);
        check($sformatf("b2b_o_%0d", c), {24'd0, O}, 32'h46);
      end
    end
    START = 1'b0;
    check("b2b_count", 32'(done_pos.size()), 32'd3);
    if (done_pos.size() == 3) begin
      check("b2b_first", 32'(done_pos[0]), 32'd8);
      check("b2b_gap1", 32'(done_pos[1] - done_pos[0]), 32'd9);
      check("b2b_gap2", 32'(done_pos[2] - done_pos[1]), 32'd9);
    end
    for (int i = 0; i < 12; i++) tick;
    check("b2b_drained", {29'd0, READY, BUSY, DONE}, 32'h4);

    // RESET at RUN cycle 4 aborts and clears the held result.
    run_op("pre_abort", 8'h0F, 8'h0F, 1'b0, 1'b0, 8'h1E, 1'b0);
    I0 = 8'h12; I1 = 8'h34; START = 1'b1;
    tick;
    START = 1'b0;
    tick; tick; tick;
    RESET = 1'b1;
    tick;
    RESET = 1'b0;
    check("abort_state", {20'd0, READY, BUSY, DONE, COUT, O}, {20'd0, 4'b1000, 8'h00});
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (DONE) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);

    // RESET and START together: START is dropped.
    I0 = 8'h01; I1 = 8'h02; RESET = 1'b1; START = 1'b1;
    tick;
    RESET = 1'b0; START = 1'b0;
    check("rst_start_same", {29'd0, READY, BUSY, DONE}, 32'h4);
    tick;
    check("rst_start_dropped", {29'd0, READY, BUSY, DONE}, 32'h4);

    // Randomized traffic vs. arithmetic model.
    RESET = 1'b1; START = 1'b0;
    tick;
    RESET = 1'b0;
    m_rem = 0; m_ready = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_o = 8'h00; m_cout = 1'b0;
    p_o = 8'h00; p_c = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      r_reset = ($urandom_range(0, 59) == 0);
      r_start = ($urandom_range(0, 1) == 1);
      r_a     = 8'($urandom);
      r_b     = 8'($urandom);
      r_cin   = 1'($urandom);
`ifdef SERIAL_ADD_CTRL_SUB_EN
      r_sub   = 1'($urandom);
`else
      r_sub   = 1'b0;
`endif
      RESET = r_reset; START = r_start; I0 = r_a; I1 = r_b; CIN = r_cin; SUB = r_sub;

      if (r_reset) begin
        m_rem = 0; m_ready = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_o = 8'h00; m_cout = 1'b0;
      end else if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_o = p_o; m_cout = p_c; m_done = 1'b1; m_ready = 1'b1; m_busy = 1'b0;
        end
      end else if (r_start) begin
        if (r_sub) begin
          p_o = r_a - r_b;
          p_c = (r_a >= r_b);
        end else begin
          full = int'(r_a) + int'(r_b) + int'(r_cin);
          p_o  = full[7:0];
          p_c  = full[8];
        end
        m_rem = WIDTH; m_ready = 1'b0; m_busy = 1'b1; m_done = 1'b0;
      end else begin
        m_ready = 1'b1; m_busy = 1'b0; m_done = 1'b0;
      end

      tick;
      check($sformatf("rand_%0d", cyc), {20'd0, READY, BUSY, DONE, COUT, O},
            {20'd0, m_ready, m_busy, m_done, m_cout, m_o});
    end
    RESET = 1'b0; START = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
